// File: rtl/k005297_arb_pkg.sv
// Shared definitions for the K005297 bus arbiter: FSM state encoding,
// counter widths and a small index-width helper.
package k005297_arb_pkg;

   // Arbiter FSM state encoding (also exported on the debug state port)
   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_ARB     = 2'd1;
   localparam logic [1:0] ARB_GRANT   = 2'd2;
   localparam logic [1:0] ARB_RELEASE = 2'd3;

   // hold_cnt must reach MAX_HOLD (up to 255), turn_cnt must hold TURN_CYC (up to 7)
   localparam int HOLD_W = 8;
   localparam int TURN_W = 3;

   // Width of a requester index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/k005297_rr_pick.sv
// Combinational circular first-one finder for the K005297 bus arbiter.
// Searches req starting one position after ptr and wrapping around, so the
// previous winner (ptr) is considered last. With prio0 set, requester 0
// wins whenever it is requesting.
module k005297_rr_pick
   import k005297_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = id_width(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            prio0,
   output logic            valid,
   output logic [IDW-1:0]  winner
);

   logic [IDW-1:0] idx;
   logic           found;

   // Scan NREQ positions after ptr; first set bit wins unless requester 0 has priority
   always_comb begin
      valid  = |req;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      if (prio0 && req[0]) begin
         winner = '0;
         found  = 1'b1;
      end
      for (int i = 1; i <= NREQ; i++) begin
         idx = IDW'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/k005297_bus_arbiter.sv
// K005297 internal data bus arbiter.
// Shares the bus among NREQ level requesters (refresh, bubble read, bubble
// write, CPU DMA). Advances only on the 2 MHz subclock tick (i_CLK2M_PCEN_n
// low) and only starts new arbitrations while i_SYS_RUN_FLAG is set.
// Grants are one-hot and non-preemptive; a grant is followed by TURN_CYC
// idle turnaround ticks.
// Optional grant watchdog: define K005297_ARB_TIMEOUT_EN to force release
// of a grant held for MAX_HOLD ticks and pulse o_TIMEOUT.
//
// Handshake: i_REQ[n] is a level request held until served; o_GNT[n] rises
// one tick after arbitration and stays high while i_REQ[n] stays high. The
// requester ends the transfer by dropping i_REQ[n]; o_GNT[n] falls on the
// tick that observes it.
module k005297_bus_arbiter
   import k005297_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int PRIO0    = 1,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 16,
   localparam int IDW     = id_width(NREQ)
)(
   input  logic              i_MCLK,
   input  logic              i_MRST_n,
   input  logic              i_CLK2M_PCEN_n,
   input  logic              i_SYS_RST_n,
   input  logic              i_SYS_RUN_FLAG,
   input  logic [NREQ-1:0]   i_REQ,
   output logic [NREQ-1:0]   o_GNT,
   output logic [IDW-1:0]    o_GNT_ID,
   output logic              o_BUS_BUSY,
   output logic              o_TIMEOUT,
   output logic [1:0]        o_DBG_STATE,
   output logic [HOLD_W-1:0] o_DBG_HOLD_CNT
);

   localparam logic [NREQ-1:0]   GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [IDW-1:0]    PTR_RST  = IDW'(NREQ - 1);
   localparam logic [TURN_W-1:0] TURN_LD  = TURN_W'(TURN_CYC);
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

   logic [1:0]        state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [IDW-1:0]    gnt_id_q;
   logic [IDW-1:0]    rr_ptr_q;
   logic [TURN_W-1:0] turn_q;
   logic [HOLD_W-1:0] hold_q;

   logic              req_any;
   logic              pick_valid;
   logic [IDW-1:0]    pick_w;

   assign req_any = |i_REQ;

   k005297_rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (i_REQ),
      .ptr    (rr_ptr_q),
      .prio0  (PRIO0 != 0),
      .valid  (pick_valid),
      .winner (pick_w)
   );

`ifdef K005297_ARB_TIMEOUT_EN
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
   logic timeout_q;

   // Watchdog pulse: set on the forced-release tick, cleared on the next tick
   always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         timeout_q <= 1'b0;
      end else if (!i_CLK2M_PCEN_n) begin
         timeout_q <= i_SYS_RST_n && (state_q == ARB_GRANT) &&
                      i_REQ[gnt_id_q] && (hold_q == HOLD_LIM);
      end
   end

   assign o_TIMEOUT = timeout_q;
`else
   assign o_TIMEOUT = 1'b0;
`endif

   // Arbiter FSM with round-robin pointer, hold and turnaround counters
   always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         state_q  <= ARB_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         rr_ptr_q <= PTR_RST;
         turn_q   <= '0;
         hold_q   <= '0;
      end else if (!i_CLK2M_PCEN_n) begin
         if (!i_SYS_RST_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            rr_ptr_q <= PTR_RST;
            turn_q   <= '0;
            hold_q   <= '0;
         end else begin
            case (state_q)
               ARB_IDLE: begin
                  if (i_SYS_RUN_FLAG && req_any)
                     state_q <= ARB_ARB;
               end
               ARB_ARB: begin
                  if (i_SYS_RUN_FLAG && pick_valid) begin
                     gnt_q    <= GNT_ONE << pick_w;
                     gnt_id_q <= pick_w;
                     rr_ptr_q <= pick_w;
                     hold_q   <= '0;
                     state_q  <= ARB_GRANT;
                  end else begin
                     state_q  <= ARB_IDLE;
                  end
               end
               ARB_GRANT: begin
                  if (!i_REQ[gnt_id_q]) begin
                     gnt_q   <= '0;
                     turn_q  <= TURN_LD;
                     state_q <= ARB_RELEASE;
                  end
`ifdef K005297_ARB_TIMEOUT_EN
                  else if (hold_q == HOLD_LIM) begin
                     gnt_q   <= '0;
                     turn_q  <= TURN_LD;
                     state_q <= ARB_RELEASE;
                  end
`endif
                  else if (hold_q != HOLD_SAT) begin
                     hold_q <= hold_q + HOLD_W'(1);
                  end
               end
               default: begin
                  // RELEASE: bus stays busy for TURN_CYC ticks after the grant drops
                  if (turn_q <= TURN_W'(1)) begin
                     turn_q  <= '0;
                     state_q <= (i_SYS_RUN_FLAG && req_any) ? ARB_ARB : ARB_IDLE;
                  end else begin
                     turn_q  <= turn_q - TURN_W'(1);
                  end
               end
            endcase
         end
      end
   end

   assign o_GNT          = gnt_q;
   assign o_GNT_ID       = gnt_id_q;
   assign o_BUS_BUSY     = (state_q == ARB_GRANT) || (state_q == ARB_RELEASE);
   assign o_DBG_STATE    = state_q;
   assign o_DBG_HOLD_CNT = hold_q;

   // Grant vector must never be multi-hot
   a_gnt_onehot: assert property (@(posedge i_MCLK) disable iff (!i_MRST_n) $onehot0(o_GNT));

endmodule

// File: tb/tb_k005297_bus_arbiter.sv
// Testbench for k005297_bus_arbiter. Two instances share all inputs:
// dut_p (PRIO0=1, TURN_CYC=2) and dut_r (PRIO0=0, TURN_CYC=1), both MAX_HOLD=8.
// Build with or without K005297_ARB_TIMEOUT_EN.
module tb_k005297_bus_arbiter;
  import k005297_arb_pkg::*;

  localparam int TURN_P = 2;
  localparam int TURN_R = 1;
  localparam int MAXH   = 8;
`ifdef K005297_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pcen_n = 1'b1;
  logic sysrst_n = 1'b1;
  logic run = 1'b1;
  logic [3:0] req = 4'b0000;
  always #5 clk = ~clk;

  logic [3:0] p_gnt, r_gnt;
  logic [1:0] p_id, r_id, p_st, r_st;
  logic p_busy, r_busy, p_to, r_to;
  logic [7:0] p_hold, r_hold;

  k005297_bus_arbiter #(.NREQ(4), .PRIO0(1), .TURN_CYC(TURN_P), .MAX_HOLD(MAXH)) dut_p (
    .i_MCLK(clk), .i_MRST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_SYS_RST_n(sysrst_n),
    .i_SYS_RUN_FLAG(run), .i_REQ(req), .o_GNT(p_gnt), .o_GNT_ID(p_id),
    .o_BUS_BUSY(p_busy), .o_TIMEOUT(p_to), .o_DBG_STATE(p_st), .o_DBG_HOLD_CNT(p_hold));

  k005297_bus_arbiter #(.NREQ(4), .PRIO0(0), .TURN_CYC(TURN_R), .MAX_HOLD(MAXH)) dut_r (
    .i_MCLK(clk), .i_MRST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_SYS_RST_n(sysrst_n),
    .i_SYS_RUN_FLAG(run), .i_REQ(req), .o_GNT(r_gnt), .o_GNT_ID(r_id),
    .o_BUS_BUSY(r_busy), .o_TIMEOUT(r_to), .o_DBG_STATE(r_st), .o_DBG_HOLD_CNT(r_hold));

  a_tb_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(p_gnt) && $onehot0(r_gnt));

  int vectors = 0;
  int errors  = 0;
  logic [3:0] exp_q[$];

  // driver: one non-tick clock edge (or two), then one tick; returns 1 time unit after the tick
  task automatic do_tick();
    repeat ($urandom_range(1, 2)) @(posedge clk);
    @(negedge clk);
    pcen_n = 1'b0;
    @(posedge clk);
    #1;
    pcen_n = 1'b1;
  endtask

  task automatic sys_flush();
    sysrst_n = 1'b0;
    req = 4'b0000;
    do_tick();
    sysrst_n = 1'b1;
  endtask

  // reference model: per-instance bus ownership, turnaround and pending-arbitration bookkeeping
  int m_owner[2], m_quiet[2], m_last[2], m_id[2], m_hold[2];
  bit m_arb[2], m_to[2];

  function automatic void model_step(input int d, input logic [3:0] rq, input logic rn,
                                     input logic srst_n, input bit prio, input int turn);
    int w;
    m_to[d] = 1'b0;
    if (!srst_n) begin
      m_owner[d] = -1; m_quiet[d] = 0; m_arb[d] = 1'b0;
      m_last[d] = 3; m_id[d] = 0; m_hold[d] = 0;
      return;
    end
    if (m_owner[d] >= 0) begin
      if (!rq[m_owner[d]]) begin
        m_owner[d] = -1; m_quiet[d] = turn;
      end else if (TO_EN && m_hold[d] == MAXH - 1) begin
        m_owner[d] = -1; m_quiet[d] = turn; m_to[d] = 1'b1;
      end else if (m_hold[d] < MAXH) begin
        m_hold[d]++;
      end
    end else if (m_quiet[d] > 0) begin
      m_quiet[d]--;
      if (m_quiet[d] == 0) m_arb[d] = rn && (rq != 4'b0000);
    end else if (m_arb[d]) begin
      m_arb[d] = 1'b0;
      if (rn && rq != 4'b0000) begin
        w = -1;
        if (prio && rq[0]) w = 0;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && rq[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
        m_owner[d] = w; m_last[d] = w; m_id[d] = w; m_hold[d] = 0;
      end
    end else begin
      m_arb[d] = rn && (rq != 4'b0000);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sysrst_n = 1'b1; run = 1'b1; req = 4'b0000;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({p_gnt, p_id, p_busy, p_to} !== 8'h00 || {r_gnt, r_id, r_busy, r_to} !== 8'h00) begin
      errors++; $display("FAIL reset_values p=%h r=%h want 00", {p_gnt, p_id, p_busy, p_to}, {r_gnt, r_id, r_busy, r_to});
    end
    vectors++;
    if (p_st !== ARB_IDLE || r_st !== ARB_IDLE) begin
      errors++; $display("FAIL reset_state p=%0d r=%0d want %0d", p_st, r_st, ARB_IDLE);
    end
    req = 4'b0100;
    do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0100 || r_gnt !== 4'b0100) begin
      errors++; $display("FAIL reset_pre_grant p=%b r=%b want 0100", p_gnt, r_gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000 || p_busy !== 1'b0 || r_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_mid_grant gnt p=%b r=%b busy p=%b r=%b want 0", p_gnt, r_gnt, p_busy, r_busy);
    end
    #1 rst_n = 1'b1;
    req = 4'b1111;
    do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001) begin
      errors++; $display("FAIL first_grant_after_reset p=%b r=%b want 0001", p_gnt, r_gnt);
    end
  endtask

  task automatic test_single();
    sys_flush();
    req = 4'b0100;
    do_tick();
    vectors++;
    if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000) begin
      errors++; $display("FAIL single_arb_tick p=%b r=%b want 0000", p_gnt, r_gnt);
    end
    do_tick();
    vectors++;
    if (p_gnt !== 4'b0100 || r_gnt !== 4'b0100 || p_id !== 2'd2 || r_id !== 2'd2 || !p_busy || !r_busy) begin
      errors++; $display("FAIL single_grant p=%b/%0d r=%b/%0d want 0100/2", p_gnt, p_id, r_gnt, r_id);
    end
    do_tick(); do_tick(); do_tick();
    req = 4'b0000;
    do_tick();
    vectors++;
    if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000 || p_busy !== 1'b1 || r_busy !== 1'b1) begin
      errors++; $display("FAIL single_release gnt p=%b r=%b busy p=%b r=%b want 0/1", p_gnt, r_gnt, p_busy, r_busy);
    end
    do_tick();
    vectors++;
    if (r_busy !== 1'b0 || p_busy !== 1'b1) begin
      errors++; $display("FAIL turnaround_1 busy p=%b r=%b want p=1 r=0", p_busy, r_busy);
    end
    do_tick();
    vectors++;
    if (p_busy !== 1'b0 || p_id !== 2'd2 || r_id !== 2'd2) begin
      errors++; $display("FAIL turnaround_2 p_busy=%b ids p=%0d r=%0d want 0,2,2", p_busy, p_id, r_id);
    end
    // synchronous flush during a grant
    req = 4'b0100;
    do_tick(); do_tick();
    sysrst_n = 1'b0;
    do_tick();
    vectors++;
    if ({p_gnt, p_id, p_busy} !== 7'h00 || {r_gnt, r_id, r_busy} !== 7'h00) begin
      errors++; $display("FAIL sys_flush p=%h r=%h want 00", {p_gnt, p_id, p_busy}, {r_gnt, r_id, r_busy});
    end
    sysrst_n = 1'b1;
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] prev_r;
    logic [3:0] exp_id;
    int since, owner;
    sys_flush();
    exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    prev_r = 4'b0000; since = 0; owner = 0;
    req = 4'b1111;
    for (int t = 0; t < 80 && exp_q.size() > 0; t++) begin
      do_tick();
      if (r_gnt != 4'b0000 && prev_r == 4'b0000) begin
        exp_id = exp_q.pop_front();
        vectors++;
        if ({2'b00, r_id} !== exp_id || r_gnt !== (4'b0001 << exp_id)) begin
          errors++; $display("FAIL rr_order got id=%0d gnt=%b want id=%0d", r_id, r_gnt, exp_id);
        end
        owner = int'(r_id); since = 0;
      end else if (r_gnt != 4'b0000) begin
        since++;
        if (since == 2) req[owner] = 1'b0;
      end else if (prev_r != 4'b0000) begin
        req[owner] = 1'b1;
      end
      prev_r = r_gnt;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_timeout grants_missing=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_priority();
    sys_flush();
    req = 4'b0010;
    do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0010) begin
      errors++; $display("FAIL prio_setup p=%b want 0010", p_gnt);
    end
    req = 4'b1110; do_tick();
    req = 4'b1111; do_tick();
    req = 4'b1101; do_tick();
    do_tick(); do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0001 || p_id !== 2'd0) begin
      errors++; $display("FAIL prio_zero_wins p=%b/%0d want 0001/0", p_gnt, p_id);
    end
    req = 4'b1100;
    do_tick(); do_tick(); do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0100 || p_id !== 2'd2) begin
      errors++; $display("FAIL prio_then_rr p=%b/%0d want 0100/2", p_gnt, p_id);
    end
  endtask

  task automatic test_run_flag();
    sys_flush();
    run = 1'b0;
    req = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      do_tick();
      vectors++;
      if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000) begin
        errors++; $display("FAIL run_off_no_grant t=%0d p=%b r=%b want 0000", t, p_gnt, r_gnt);
      end
    end
    run = 1'b1;
    do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001) begin
      errors++; $display("FAIL run_on_grant p=%b r=%b want 0001", p_gnt, r_gnt);
    end
    run = 1'b0;
    do_tick(); do_tick(); do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001) begin
      errors++; $display("FAIL run_drop_holds p=%b r=%b want 0001", p_gnt, r_gnt);
    end
    req = 4'b1110;
    do_tick(); do_tick(); do_tick(); do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000 || p_busy || r_busy || p_st !== ARB_IDLE || r_st !== ARB_IDLE) begin
      errors++; $display("FAIL run_drop_idle gnt p=%b r=%b st p=%0d r=%0d want 0 idle", p_gnt, r_gnt, p_st, r_st);
    end
    run = 1'b1;
  endtask

  task automatic test_watchdog();
    sys_flush();
    req = 4'b0001;
    do_tick(); do_tick();
    vectors++;
    if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001) begin
      errors++; $display("FAIL wd_grant p=%b r=%b want 0001", p_gnt, r_gnt);
    end
    if (TO_EN) begin
      for (int t = 1; t <= 7; t++) begin
        do_tick();
        vectors++;
        if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001 || p_to || r_to) begin
          errors++; $display("FAIL wd_hold t=%0d p=%b r=%b to=%b%b want 0001 to=0", t, p_gnt, r_gnt, p_to, r_to);
        end
      end
      do_tick();
      vectors++;
      if (p_gnt !== 4'b0000 || r_gnt !== 4'b0000 || p_to !== 1'b1 || r_to !== 1'b1) begin
        errors++; $display("FAIL wd_fire p=%b r=%b to=%b%b want 0000 to=1", p_gnt, r_gnt, p_to, r_to);
      end
      do_tick();
      vectors++;
      if (p_to !== 1'b0 || r_to !== 1'b0) begin
        errors++; $display("FAIL wd_pulse_width to=%b%b want 0", p_to, r_to);
      end
    end else begin
      for (int t = 1; t <= 20; t++) begin
        do_tick();
        vectors++;
        if (p_gnt !== 4'b0001 || r_gnt !== 4'b0001 || p_to || r_to) begin
          errors++; $display("FAIL nowd_hold t=%0d p=%b r=%b to=%b%b want 0001 to=0", t, p_gnt, r_gnt, p_to, r_to);
        end
      end
      vectors++;
      if (p_hold !== 8'(MAXH) || r_hold !== 8'(MAXH)) begin
        errors++; $display("FAIL hold_saturate p=%0d r=%0d want %0d", p_hold, r_hold, MAXH);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] eg[2];
    logic exp_busy[2];
    sysrst_n = 1'b0; req = 4'b0000; run = 1'b1;
    do_tick();
    model_step(0, req, run, sysrst_n, 1'b1, TURN_P);
    model_step(1, req, run, sysrst_n, 1'b0, TURN_R);
    sysrst_n = 1'b1;
    for (int t = 0; t < 500; t++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      run = ($urandom_range(0, 9) != 0);
      sysrst_n = ($urandom_range(0, 99) != 0);
      do_tick();
      model_step(0, req, run, sysrst_n, 1'b1, TURN_P);
      model_step(1, req, run, sysrst_n, 1'b0, TURN_R);
      for (int d = 0; d < 2; d++) begin
        eg[d] = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
        exp_busy[d] = (m_owner[d] >= 0) || (m_quiet[d] > 0);
      end
      vectors++;
      if ({p_gnt, p_id, p_busy, p_to} !== {eg[0], 2'(m_id[0]), exp_busy[0], m_to[0]}) begin
        errors++; $display("FAIL rand_prio t=%0d got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                           t, p_gnt, p_id, p_busy, p_to, eg[0], m_id[0], exp_busy[0], m_to[0]);
      end
      vectors++;
      if ({r_gnt, r_id, r_busy, r_to} !== {eg[1], 2'(m_id[1]), exp_busy[1], m_to[1]}) begin
        errors++; $display("FAIL rand_rr t=%0d got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                           t, r_gnt, r_id, r_busy, r_to, eg[1], m_id[1], exp_busy[1], m_to[1]);
      end
    end
    sysrst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_run_flag();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
